// File: rtl/timeout_controller.sv
// Programmable 100 ms timeout sequencer; owns reset/enable of the timebase chain.
// Optional periodic mode: define TIMEOUT_AUTO_RELOAD_EN.
package timeout_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } tstate_t;
endpackage

module timeout_controller
  import timeout_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_start,
  input  logic         cmd_pause,
  input  logic         cmd_clear,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         chain_rst_n,
  output logic         chain_en,
  output logic [W-1:0] remaining,
  output logic [1:0]   state,
  output logic         busy,
  output logic         expired
);

  tstate_t st_q;
  logic    clr_c;
  logic    start_c;
  logic    pause_c;
  logic    term;

  assign clr_c   = cmd_clear;
  assign start_c = cmd_start & ~cmd_clear;
  assign pause_c = cmd_pause & ~cmd_clear & ~cmd_start;
  assign term    = tick && (remaining == W'(1));
  assign state   = st_q;

`ifdef TIMEOUT_AUTO_RELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (start_c) begin
      reload_q <= load_val;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q        <= S_IDLE;
      remaining   <= '0;
      chain_rst_n <= 1'b0;
      chain_en    <= 1'b0;
      busy        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      expired <= 1'b0;
      unique case (1'b1)
        clr_c: begin
          st_q        <= S_IDLE;
          remaining   <= '0;
          chain_rst_n <= 1'b0;
          chain_en    <= 1'b0;
          busy        <= 1'b0;
        end
        start_c: begin
          if (load_val == '0) begin
            st_q        <= S_DONE;
            remaining   <= '0;
            expired     <= 1'b1;
            chain_rst_n <= 1'b0;
            chain_en    <= 1'b0;
            busy        <= 1'b0;
          end else begin
            st_q        <= S_RUN;
            remaining   <= load_val;
            // a retrigger from RUN/PAUSE re-phases the chain with a 1-cycle reset
            chain_rst_n <= ~busy;
            chain_en    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        default: begin
          unique case (st_q)
            S_RUN: begin
              chain_rst_n <= 1'b1;
              if (term) begin
                expired <= 1'b1;
`ifdef TIMEOUT_AUTO_RELOAD_EN
                remaining <= reload_q;
                if (pause_c) begin
                  st_q     <= S_PAUSE;
                  chain_en <= 1'b0;
                end
`else
                remaining   <= '0;
                st_q        <= S_DONE;
                chain_rst_n <= 1'b0;
                chain_en    <= 1'b0;
                busy        <= 1'b0;
`endif
              end else begin
                if (tick) begin
                  remaining <= remaining - 1'b1;
                end
                if (pause_c) begin
                  st_q     <= S_PAUSE;
                  chain_en <= 1'b0;
                end
              end
            end
            S_PAUSE: begin
              if (pause_c) begin
                st_q     <= S_RUN;
                chain_en <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timeout_controller.sv
// Directed bench for timeout_controller with a per-cycle reference model.
// Periodic-mode checks run when TIMEOUT_AUTO_RELOAD_EN is defined.
module tb_timeout_controller;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_start = 1'b0;
  logic         cmd_pause = 1'b0;
  logic         cmd_clear = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         tick = 1'b0;
  logic         chain_rst_n;
  logic         chain_en;
  logic [W-1:0] remaining;
  logic [1:0]   state;
  logic         busy;
  logic         expired;

  int checks = 0;
  int errors = 0;
  int ex_cnt = 0;
  bit cmp_on = 1'b0;

  // reference model: state 0 idle, 1 run, 2 pause, 3 done
  int m_state = 0;
  int m_rem = 0;
  int m_reload = 0;
  bit m_exp = 1'b0;
  bit m_restart = 1'b0;

`ifdef TIMEOUT_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  timeout_controller #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause),
    .cmd_clear(cmd_clear), .load_val(load_val),
    .tick(tick), .chain_rst_n(chain_rst_n),
    .chain_en(chain_en), .remaining(remaining),
    .state(state), .busy(busy), .expired(expired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_exp = 1'b0;
    m_restart = 1'b0;
    if (!rst || cmd_clear) begin
      m_state = 0;
      m_rem = 0;
      if (!rst) m_reload = 0;
    end else if (cmd_start) begin
      m_reload = int'(load_val);
      if (load_val == 0) begin
        m_state = 3;
        m_rem = 0;
        m_exp = 1'b1;
      end else begin
        m_restart = (m_state == 1 || m_state == 2);
        m_state = 1;
        m_rem = int'(load_val);
      end
    end else if (m_state == 1) begin
      if (tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_exp = 1'b1;
          if (AR) m_rem = m_reload;
          else m_state = 3;
        end
      end
      if (cmd_pause && m_state == 1) m_state = 2;
    end else if (m_state == 2) begin
      if (cmd_pause) m_state = 1;
    end
  end

  always @(negedge clk) begin
    if (expired === 1'b1) ex_cnt++;
    if (cmp_on) begin
      bit e_busy;
      bit e_crst;
      bit e_en;
      e_busy = (m_state == 1 || m_state == 2);
      e_crst = e_busy && !m_restart;
      e_en = (m_state == 1);
      checks++;
      if ($isunknown({state, remaining, busy, expired, chain_rst_n, chain_en})
          || int'(state) != m_state || int'(remaining) != m_rem
          || busy != e_busy || expired != m_exp
          || chain_rst_n != e_crst || chain_en != e_en) begin
        errors++;
        $display("FAIL model t=%0t st=%0d/%0d rem=%0d/%0d busy=%0b/%0b exp=%0b/%0b crst=%0b/%0b en=%0b/%0b",
                 $time, state, m_state, remaining, m_rem, busy, e_busy,
                 expired, m_exp, chain_rst_n, e_crst, chain_en, e_en);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit c,
                     input int lv, input bit t);
    @(negedge clk);
    cmd_start = s;
    cmd_pause = p;
    cmd_clear = c;
    load_val = W'(lv);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic tk(input int gap);
    idle(gap);
    cyc(0, 0, 0, 0, 1);
  endtask

  int base;

  initial begin
    rst = 1'b0;
    idle(3);
    chk("rst_state", int'(state), 0);
    chk("rst_crst", int'(chain_rst_n), 0);
    chk("rst_en", int'(chain_en), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_exp", int'(expired), 0);
    cmp_on = 1'b1;
    rst = 1'b1;
    idle(1);

`ifndef TIMEOUT_AUTO_RELOAD_EN
    cyc(1, 0, 0, 3, 0);
    chk("t2_rem3", int'(remaining), 3);
    chk("t2_run", int'(state), 1);
    chk("t2_crst", int'(chain_rst_n), 1);
    tk(9);
    chk("t2_rem2", int'(remaining), 2);
    tk(9);
    chk("t2_rem1", int'(remaining), 1);
    tk(9);
    chk("t2_rem0", int'(remaining), 0);
    chk("t2_exp", int'(expired), 1);
    chk("t2_done", int'(state), 3);
    chk("t2_en", int'(chain_en), 0);
    idle(1);
    chk("t2_exp_low", int'(expired), 0);

    cyc(1, 0, 0, 5, 0);
    base = ex_cnt;
    tk(2);
    tk(2);
    chk("t3_rem3", int'(remaining), 3);
    cyc(0, 1, 0, 0, 0);
    chk("t3_pause", int'(state), 2);
    chk("t3_pause_en", int'(chain_en), 0);
    for (int i = 0; i < 4; i++) tk(2);
    chk("t3_frozen", int'(remaining), 3);
    cyc(0, 1, 0, 0, 0);
    chk("t3_resume", int'(state), 1);
    chk("t3_resume_crst", int'(chain_rst_n), 1);
    tk(2);
    chk("t3_rem2", int'(remaining), 2);
    tk(2);
    tk(2);
    chk("t3_rem0", int'(remaining), 0);
    idle(1);
    chk("t3_exp_once", ex_cnt - base, 1);

    cyc(1, 0, 0, 1, 0);
    chk("t4_rem1", int'(remaining), 1);
    cyc(1, 0, 1, 7, 1);
    chk("t4_idle", int'(state), 0);
    chk("t4_rem", int'(remaining), 0);
    chk("t4_exp", int'(expired), 0);
    cyc(0, 1, 0, 0, 0);
    chk("idle_pause", int'(state), 0);

    cyc(1, 0, 0, 0, 0);
    chk("t5_done", int'(state), 3);
    chk("t5_exp", int'(expired), 1);
    idle(1);
    chk("t5_exp_low", int'(expired), 0);
    cyc(1, 0, 0, 2, 0);
    chk("t5_run", int'(state), 1);
    chk("t5_rem2", int'(remaining), 2);

    cyc(1, 0, 0, 9, 1);
    chk("retrig_rem", int'(remaining), 9);
    chk("retrig_crst", int'(chain_rst_n), 0);
    idle(1);
    chk("retrig_crst_rel", int'(chain_rst_n), 1);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4, 0);
    chk("pause_start_rem", int'(remaining), 4);
    chk("pause_start_st", int'(state), 1);
    tk(1);
    tk(1);
    tk(1);
    cyc(0, 1, 0, 0, 1);
    chk("term_pause_st", int'(state), 3);
    chk("term_pause_exp", int'(expired), 1);
`else
    cyc(1, 0, 0, 2, 0);
    chk("t6_rem2", int'(remaining), 2);
    for (int i = 1; i <= 6; i++) begin
      tk(3);
      chk("t6_rem", int'(remaining), (i % 2 == 1) ? 1 : 2);
      chk("t6_exp", int'(expired), (i % 2 == 0) ? 1 : 0);
      chk("t6_st", int'(state), 1);
    end
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("p1_exp", int'(expired), 1);
    chk("p1_rem", int'(remaining), 1);
    cyc(1, 0, 0, 0, 0);
    chk("ar_zero_done", int'(state), 3);
`endif

    cyc(1, 0, 0, 6, 0);
    tk(1);
    chk("mid_rem5", int'(remaining), 5);
    rst = 1'b0;
    idle(1);
    chk("mid_rst_st", int'(state), 0);
    chk("mid_rst_rem", int'(remaining), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_crst", int'(chain_rst_n), 0);
    rst = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
